multiplier_scheduler: RTL and testbench

Shares one serial `Multiplier` instance (BITS-bit × BITS-bit, 2·BITS-bit product) between REQUESTERS independent clients. Arbitration is round-robin and fair. The block sequences the multiplier's start/finished protocol and returns each product tagged with the requester's index through a valid/ready output. It sits between the client blocks and the shared multiplier datapath; clients never drive the multiplier directly.

---
 rtl/multiplier_scheduler_pkg.sv | 16 +
 rtl/multiplier.sv | 52 +++++
 rtl/round_robin_arbiter.sv | 34 +++
 rtl/multiplier_scheduler.sv | 140 ++++++++++++++
 tb/tb_multiplier_scheduler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_scheduler_pkg.sv
// Shared definitions for the multiplier scheduler and its arbiter.
package multiplier_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width of a binary index selecting one of n requesters (at least 1 bit).
   function automatic int id_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multiplier.sv
// Serial shift-add unsigned multiplier. One i_start pulse loads the operands;
// BITS cycles later o_finished is high for one cycle with o_product valid.
module multiplier #(
   parameter int BITS = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [BITS-1:0]   i_multiplicand,
   input  logic [BITS-1:0]   i_multiplier,
   output logic [2*BITS-1:0] o_product,
   output logic              o_finished
);

   localparam int CW = $clog2(BITS + 1);

   logic [2*BITS-1:0] acc;
   logic [2*BITS-1:0] addend;
   logic [BITS-1:0]   mplr;
   logic [CW-1:0]     count;
   logic              running;

   // Product including the current step, so the final step is visible in the
   // same cycle o_finished is raised.
   assign o_product  = acc + (mplr[0] ? addend : '0);
   assign o_finished = running && (count == CW'(1));

   // One partial product per cycle; count is a down-counter ending at 1.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         acc     <= '0;
         addend  <= '0;
         mplr    <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (i_start) begin
         acc     <= '0;
         addend  <= {{BITS{1'b0}}, i_multiplicand};
         mplr    <= i_multiplier;
         count   <= CW'(BITS);
         running <= 1'b1;
      end else if (running) begin
         acc    <= o_product;
         addend <= addend << 1;
         mplr   <= mplr >> 1;
         count  <= count - CW'(1);
         if (count == CW'(1))
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at the pointer
// and returns the first hit as a one-hot grant plus its binary index.
module round_robin_arbiter
   import multiplier_scheduler_pkg::*;
#(
   parameter int  REQUESTERS = 4,
   localparam int ID_BITS    = id_bits(REQUESTERS)
) (
   input  logic [REQUESTERS-1:0] request,
   input  logic [ID_BITS-1:0]    pointer,
   output logic [REQUESTERS-1:0] grant,
   output logic [ID_BITS-1:0]    index,
   output logic                  any
);

   logic [ID_BITS-1:0] cand;

   // Priority order pointer, pointer+1, ... wrapping through the index width.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         cand = pointer + ID_BITS'(i);
         if (!any && request[cand]) begin
            any         = 1'b1;
            index       = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multiplier_scheduler.sv
// Shares one serial multiplier between REQUESTERS clients with round-robin
// arbitration; results are returned tagged with the owner's index.
//
//   state | meaning
//   IDLE  | waiting for a request; the first IDLE cycle after DONE is a
//         | settle bubble in which no grant is issued
//   START | multiplier started from latched operands, o_grant pulse
//   BUSY  | multiplier running, waiting for o_finished
//   DONE  | o_valid high, product held until i_ready
module multiplier_scheduler
   import multiplier_scheduler_pkg::*;
#(
   parameter int  BITS       = 8,
   parameter int  REQUESTERS = 4,
   localparam int ID_BITS    = id_bits(REQUESTERS)
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [REQUESTERS-1:0]        i_request,
   input  logic [REQUESTERS*BITS-1:0]   i_multiplicand,
   input  logic [REQUESTERS*BITS-1:0]   i_multiplier,
   output logic [REQUESTERS-1:0]        o_grant,
   output logic                         o_busy,
   output logic                         o_valid,
   output logic [ID_BITS-1:0]           o_id,
   output logic [2*BITS-1:0]            o_product,
   input  logic                         i_ready
);

   state_t             state;
   state_t             state_next;
   logic [ID_BITS-1:0] ptr;
   logic [ID_BITS-1:0] id;
   logic               cooldown;
   logic [BITS-1:0]    op_a;
   logic [BITS-1:0]    op_b;
   logic [BITS-1:0]    sel_a;
   logic [BITS-1:0]    sel_b;
   logic [2*BITS-1:0]  product;

   logic [REQUESTERS-1:0] arb_grant;
   logic [ID_BITS-1:0]    arb_index;
   logic                  arb_any;
   logic                  launch;

   logic                  mul_start;
   logic [2*BITS-1:0]     mul_product;
   logic                  mul_finished;

   round_robin_arbiter #(
      .REQUESTERS (REQUESTERS)
   ) u_arbiter (
      .request (i_request),
      .pointer (ptr),
      .grant   (arb_grant),
      .index   (arb_index),
      .any     (arb_any)
   );

   multiplier #(
      .BITS (BITS)
   ) u_multiplier (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_start        (mul_start),
      .i_multiplicand (op_a),
      .i_multiplier   (op_b),
      .o_product      (mul_product),
      .o_finished     (mul_finished)
   );

   assign launch    = (state == IDLE) && !cooldown && arb_any;
   assign mul_start = (state == START);
   assign o_busy    = (state != IDLE);
   assign o_valid   = (state == DONE);
   assign o_id      = id;
   assign o_product = product;

   // Winner's operands selected by AND-OR of the one-hot grant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (arb_grant[k]) begin
            sel_a = sel_a | i_multiplicand[k*BITS +: BITS];
            sel_b = sel_b | i_multiplier[k*BITS +: BITS];
         end
      end
   end

   // State register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (launch)       state_next = START;
         START:                     state_next = BUSY;
         BUSY:    if (mul_finished) state_next = DONE;
         DONE:    if (i_ready)      state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   // Grant pulse for the latched owner while the multiplier is started.
   always_comb begin
      o_grant = '0;
      if (state == START)
         o_grant[id] = 1'b1;
   end

   // Winner/pointer/operand capture on launch, product capture on finish.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ptr      <= '0;
         id       <= '0;
         cooldown <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         product  <= '0;
      end else begin
         cooldown <= (state == DONE) && i_ready;
         if (launch) begin
            id   <= arb_index;
            ptr  <= arb_index + ID_BITS'(1);
            op_a <= sel_a;
            op_b <= sel_b;
         end
         if ((state == BUSY) && mul_finished)
            product <= mul_product;
      end
   end

endmodule

// File: tb/tb_multiplier_scheduler.sv
// Directed bench for multiplier_scheduler (BITS=8, REQUESTERS=4).
module tb_multiplier_scheduler;

   localparam int BITS = 8;
   localparam int R    = 4;

   logic          i_clock = 1'b0;
   logic          i_reset;
   logic [R-1:0]  i_request;
   logic [R*BITS-1:0] i_multiplicand;
   logic [R*BITS-1:0] i_multiplier;
   logic [R-1:0]  o_grant;
   logic          o_busy;
   logic          o_valid;
   logic [1:0]    o_id;
   logic [2*BITS-1:0] o_product;
   logic          i_ready;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   typedef struct {
      int          client;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec_t;

   vec_t vecs[7];

   multiplier_scheduler #(
      .BITS       (BITS),
      .REQUESTERS (R)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_request      (i_request),
      .i_multiplicand (i_multiplicand),
      .i_multiplier   (i_multiplier),
      .o_grant        (o_grant),
      .o_busy         (o_busy),
      .o_valid        (o_valid),
      .o_id           (o_id),
      .o_product      (o_product),
      .i_ready        (i_ready)
   );

   always #5 i_clock = ~i_clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
      cycle++;
   endtask

   task automatic set_ops(input int c, input logic [7:0] a, input logic [7:0] b);
      i_multiplicand[c*BITS +: BITS] = a;
      i_multiplier[c*BITS +: BITS]   = b;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (o_grant == '0 && n < 60);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_valid && n < 60);
   endtask

   // Request from a settled IDLE with i_ready high; leaves the block settled.
   task automatic do_single(input string name, input int c, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] exp);
      int n;
      set_ops(c, a, b);
      i_request[c] = 1'b1;
      tick();
      check({name, "_grant"}, o_grant, 32'(1 << c));
      i_request[c] = 1'b0;
      wait_valid(n);
      check({name, "_latency"}, n, 9);
      check({name, "_id"}, o_id, c);
      check({name, "_product"}, o_product, exp);
      tick();
      check({name, "_valid_drop"}, o_valid, 0);
      tick();
   endtask

   initial begin
      int n;
      int last;
      int errs;
      logic [15:0] exp4[4];

      vecs[0] = '{2,   8'd3, 8'd5,   16'd15};
      vecs[1] = '{0,   8'd0, 8'd200, 16'd0};
      vecs[2] = '{1, 8'd255, 8'd1,   16'd255};
      vecs[3] = '{3, 8'd255, 8'd255, 16'd65025};
      vecs[4] = '{1,   8'd7, 8'd9,   16'd63};
      vecs[5] = '{0,  8'd12, 8'd13,  16'd156};
      vecs[6] = '{3, 8'd200, 8'd0,   16'd0};
      exp4[0] = 16'd200;
      exp4[1] = 16'd231;
      exp4[2] = 16'd264;
      exp4[3] = 16'd299;

      i_reset        = 1'b1;
      i_request      = '0;
      i_multiplicand = '0;
      i_multiplier   = '0;
      i_ready        = 1'b1;
      #1;
      check("rst_grant",   o_grant,   0);
      check("rst_busy",    o_busy,    0);
      check("rst_valid",   o_valid,   0);
      check("rst_id",      o_id,      0);
      check("rst_product", o_product, 0);
      tick();
      tick();
      i_reset = 1'b0;
      tick();

      for (int v = 0; v < 7; v++)
         do_single($sformatf("vec%0d", v), vecs[v].client, vecs[v].a, vecs[v].b, vecs[v].prod);

      // All four at once from pointer 0: strict rotation, 12 cycles apart.
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      tick();
      for (int c = 0; c < R; c++)
         set_ops(c, 8'(10 + c), 8'(20 + c));
      i_request = 4'hF;
      last = 0;
      for (int k = 0; k < R; k++) begin
         wait_grant(n);
         check($sformatf("all_grant%0d", k), o_grant, 32'(1 << k));
         if (k > 0)
            check($sformatf("all_spacing%0d", k), cycle - last, 12);
         last = cycle;
         i_request[k] = 1'b0;
         wait_valid(n);
         check($sformatf("all_id%0d", k), o_id, k);
         check($sformatf("all_product%0d", k), o_product, exp4[k]);
      end

      // After a grant to client 3 the pointer is back at 0.
      i_request = 4'b1001;
      wait_grant(n);
      check("wrap_grant", o_grant, 32'b0001);
      i_request = '0;
      wait_valid(n);
      check("wrap_product", o_product, 200);
      tick();
      tick();

      // Clients 0 and 3 requesting continuously alternate.
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      tick();
      i_request = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         wait_grant(n);
         check($sformatf("fair_grant%0d", k), o_grant, (k % 2 == 0) ? 32'b0001 : 32'b1000);
         if (k == 3)
            i_request = '0;
         wait_valid(n);
         check($sformatf("fair_product%0d", k), o_product, (k % 2 == 0) ? 200 : 299);
      end
      tick();
      tick();

      // Backpressure: 20 stalled cycles in DONE with another client pending.
      set_ops(3, 8'd255, 8'd255);
      set_ops(1, 8'd100, 8'd3);
      i_ready      = 1'b0;
      i_request[3] = 1'b1;
      wait_grant(n);
      check("bp_grant", o_grant, 32'b1000);
      i_request[3] = 1'b0;
      i_request[1] = 1'b1;
      wait_valid(n);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         if (!o_valid || o_product != 16'd65025 || o_grant != '0 || o_id != 2'd3)
            errs++;
         tick();
      end
      check("bp_stall_hold", errs, 0);
      check("bp_product", o_product, 65025);
      i_ready = 1'b1;
      tick();
      check("bp_valid_drop", o_valid, 0);
      wait_grant(n);
      check("bp_next_delay", n, 2);
      check("bp_next_grant", o_grant, 32'b0010);
      i_request[1] = 1'b0;
      wait_valid(n);
      check("bp_next_id", o_id, 1);
      check("bp_next_product", o_product, 300);
      tick();
      tick();

      // Reset while the multiplier is running.
      set_ops(2, 8'd50, 8'd60);
      i_request[2] = 1'b1;
      tick();
      check("mid_grant", o_grant, 32'b0100);
      i_request[2] = 1'b0;
      repeat (4) tick();
      check("mid_busy", o_busy, 1);
      i_reset = 1'b1;
      #1;
      check("mid_rst_grant",   o_grant,   0);
      check("mid_rst_busy",    o_busy,    0);
      check("mid_rst_valid",   o_valid,   0);
      check("mid_rst_id",      o_id,      0);
      check("mid_rst_product", o_product, 0);
      tick();
      i_reset = 1'b0;
      errs = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (o_grant != '0 || o_busy || o_valid)
            errs++;
      end
      check("mid_no_regrant", errs, 0);
      do_single("post_rst", 1, 8'd7, 8'd9, 16'd63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
